// File: rtl/rr_mux_nx1.sv
// Registered N:1 valid/ready multiplexer with a round-robin arbiter and a one-stage output register.
// Define RR_MUX_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module rr_mux_nx1 #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  input  logic               out_ready
);

  // Handshake: a word moves on any port at a rising clk edge where valid && ready.
  // The output stage accepts a new word whenever it is empty or being drained this cycle,
  // so in_ready depends combinationally on out_ready but never on in_data.

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;
  logic [SW-1:0]    ptr_q;

  logic             load;
  logic             gnt_found;
  logic [SW-1:0]    gnt_idx;
  logic [SW-1:0]    cand;
  logic             in_xfer;
  logic [WIDTH-1:0] sel_data;

  // Circular search for the first pending channel at or above ptr_q.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = SW'((int'(ptr_q) + k) % N);
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign in_xfer  = load && gnt_found;
  assign sel_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    if (in_xfer) in_ready[gnt_idx] = 1'b1;
  end

  // A drain with no refill empties the register; data and select keep their last value.
  always_comb begin
    out_valid_d = load ? in_xfer : out_valid_q;
    out_data_d  = in_xfer ? sel_data : out_data_q;
    out_sel_d   = in_xfer ? gnt_idx : out_sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [SW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (in_xfer) ptr_d = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Directed bench for rr_mux_nx1: a behavioural model checked every negedge plus hand-computed
// expectations for reset, rotation, stall, sparse wrap, drain+load and asynchronous reset.
module tb_rr_mux_nx1;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SW    = $clog2(N);
`ifdef RR_MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_sel;
  logic               out_ready;

  always #5 clk = ~clk;

  rr_mux_nx1 #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Output register contents plus the channel the next search starts from.
  int               m_valid, m_sel, m_ptr;
  logic [WIDTH-1:0] m_data;

  function automatic int model_grant(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else begin
      int g;
      bit ld;
      ld = (m_valid == 0) || out_ready;
      g  = ld ? model_grant(in_valid, m_ptr) : -1;
      if (g >= 0) begin
        m_valid = 1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_sel   = g;
        m_ptr   = FIXED ? 0 : (g + 1) % N;
      end else if (ld) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("model out_valid", int'(out_valid), m_valid);
    check("model out_data", int'(out_data), int'(m_data));
    check("model out_sel", int'(out_sel), m_sel);
    if (rst_n) begin
      logic [N-1:0] exp_rdy;
      int g;
      exp_rdy = '0;
      g = ((m_valid == 0) || out_ready) ? model_grant(in_valid, m_ptr) : -1;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("model in_ready", int'(in_ready), int'(exp_rdy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_data(input int ch, input logic [WIDTH-1:0] val);
    in_data[ch*WIDTH +: WIDTH] = val;
  endtask

  // Apply inputs, then return 1 time unit after the next rising edge.
  task automatic step(input logic [N-1:0] v, input logic ordy);
    in_valid  = v;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int v, input int d, input int s);
    check({name, " out_valid"}, int'(out_valid), v);
    check({name, " out_data"}, int'(out_data), d);
    check({name, " out_sel"}, int'(out_sel), s);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + 8'(i));

    // Reset held with every channel valid.
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0);

    rst_n = 1'b1;
    step(4'hF, 1'b1);
    expect_out("first", 1, 'hA0, 0);

    // Continuous rotation with no bubbles.
    for (int i = 1; i <= 5; i++) begin
      int s;
      s = FIXED ? 0 : i % N;
      step(4'hF, 1'b1);
      expect_out("rotate", 1, 'hA0 + s, s);
    end

    // Stall: load 0x55 from ch2, then hold out_ready low.
    set_data(2, 8'h55);
    step(4'b0100, 1'b1);
    expect_out("stall load", 1, 'h55, 2);
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b0);
      expect_out("stall hold", 1, 'h55, 2);
      check("stall in_ready", int'(in_ready), 0);
    end
    set_data(2, 8'hA2);
    step(4'hF, 1'b1);
    expect_out("stall release", 1, FIXED ? 'hA0 : 'hA3, FIXED ? 0 : 3);

    // Sparse requests wrapping through ptr=0, then drain to empty.
    step(4'b1000, 1'b1);
    expect_out("sparse ch3", 1, 'hA3, 3);
    step(4'b0010, 1'b1);
    expect_out("sparse ch1", 1, 'hA1, 1);
    step(4'b0000, 1'b1);
    expect_out("drain", 0, 'hA1, 1);
    step(4'b0000, 1'b1);
    expect_out("idle", 0, 'hA1, 1);
    check("idle in_ready", int'(in_ready), 0);

    // Drain and refill in the same cycle.
    step(4'b0100, 1'b1);
    expect_out("b2b first", 1, 'hA2, 2);
    set_data(0, 8'h12);
    step(4'b0001, 1'b1);
    expect_out("b2b refill", 1, 'h12, 0);

    // Asynchronous reset pulse between edges.
    in_valid  = '0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 expect_out("async reset", 0, 0, 0);
    #1 rst_n = 1'b1;
    step(4'hF, 1'b1);
    expect_out("post reset", 1, 'h12, 0);
    step(4'hF, 1'b1);
    expect_out("post reset next", 1, FIXED ? 'h12 : 'hA1, FIXED ? 0 : 1);

    step(4'h0, 1'b1);
    step(4'h0, 1'b1);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
